spi_peripheral: RTL
===================

// Module: spi_peripheral
// PURPOSE
//  SPI write-only register slave feeding pwm_peripheral. Receives 16-bit frames on ui_in[2:0]
//  (SCLK, COPI, nCS), decodes a 7-bit address, updates one of five 8-bit control registers.
//  Registers drive en_reg_out_*, en_reg_pwm_* and pwm_duty_cycle directly. SPI mode 0, MSB first.
// PARAMETERS
//  SYNC_STAGES  2   synchroniser flops per SPI input (>=2); an edge-detect flop is added after them
//  MAX_ADDR     4   highest valid register address; frames above it are discarded
// PORTS
//  clk              in   1  system clock; all logic in this domain
//  rst_n            in   1  asynchronous active-low reset
//  sclk             in   1  SPI clock (async to clk)
//  copi             in   1  SPI data in (async)
//  ncs              in   1  SPI chip select, active low (async)
//  en_reg_out_7_0   out  8  addr 0x00: output enable uo_out[7:0]
//  en_reg_out_15_8  out  8  addr 0x01: output enable uio_out[7:0]
//  en_reg_pwm_7_0   out  8  addr 0x02: PWM mode uo_out[7:0]
//  en_reg_pwm_15_8  out  8  addr 0x03: PWM mode uio_out[7:0]
//  pwm_duty_cycle   out  8  addr 0x04: duty (0x00=0%, 0xFF=100%)
//  wr_strobe        out  1  one-clk pulse when a register is committed (debug/test)
// BEHAVIOUR
//  Reset: all five registers 8'h00, wr_strobe 0, bit counter 0, shift reg 0, sync flops
//   sclk=0 copi=0 ncs=1. Async assert, sync-safe deassert via the clk domain.
//  Sync: each input through SYNC_STAGES flops + 1 history flop; edges = synced & ~history.
//  Frame: bit[15]=R/W (1=write), bits[14:8]=address, bits[7:0]=data.
//  ncs falling edge (synced): clear bit counter, clear overflow flag.
//  sclk rising edge (synced) while synced ncs=0: shift_reg <= {shift_reg[14:0], copi_sync};
//   count++; count 16 + further edge -> set overflow, count holds at 16.
//  sclk edges while ncs high: ignored.
//  ncs rising edge (synced): commit iff count==16 & !overflow & shift_reg[15]==1 & addr<=MAX_ADDR.
//   Commit: target register <= shift_reg[7:0] and wr_strobe=1, both at the same clk edge
//   (1 clk after edge detected; <= SYNC_STAGES+2 clk after the pad ncs rise).
//  Discard (no register change, no strobe): read frames (bit15=0), short frames (<16 bits),
//   long frames (>16 bits), address > MAX_ADDR.
//  Simultaneous sclk rise and ncs rise in the same clk: the ncs rise wins; the sclk edge is not shifted.
//  Reset mid-frame: partial frame is lost; registers return to 0; the next full frame works normally.
//  Timing contract: SCLK high and low time each >= SYNC_STAGES+2 clk periods (SCLK <= clk/8 default);
//   ncs high time between frames >= SYNC_STAGES+2 clk.
//  Registers hold their value indefinitely between writes; no read-back path.
// STRUCTURE
//  Shared package spi_regs_pkg: localparams ADDR_EN_OUT_LO=0, ADDR_EN_OUT_HI=1, ADDR_EN_PWM_LO=2,
//   ADDR_EN_PWM_HI=3, ADDR_DUTY=4, FRAME_BITS=16, RW_WRITE=1'b1; also used by pwm_peripheral tests.
//  Sub-module sync_edge_det (SYNC_STAGES param): synchroniser + rise/fall pulse outputs, x3 instances.
//  Top-level wiring: sclk=ui_in[0], copi=ui_in[1], ncs=ui_in[2].
// TESTING
//  1 Write 0x00<-0xF0 (frame 0x80F0) -> en_reg_out_7_0=0xF0, one wr_strobe, other regs still 0x00.
//  2 Write 0x04<-0x80, then 0x04<-0x00 -> pwm_duty_cycle 0x80, then 0x00; two strobes total.
//  3 Read frame 0x0155 and write to addr 0x05 (0x8555) -> no register change, no strobe.
//  4 Frame of 15 bits and frame of 17 bits to addr 0x01 -> both discarded; next valid 0x81AA -> 0xAA.
//  5 Assert rst_n low mid-frame after 8 bits, release, send 0x8233 -> en_reg_pwm_7_0=0x33, others 0.
//  6 Sweep SCLK at clk/8 and clk/20, random CDC jitter, all 5 addresses -> scoreboard matches.

Source files
------------

// File: rtl/spi_regs_pkg.sv
// Shared register map and frame layout for the SPI control-register slave.
// Also used by the pwm_peripheral tests to address the same registers.
package spi_regs_pkg;

    localparam int   ADDR_EN_OUT_LO = 0;
    localparam int   ADDR_EN_OUT_HI = 1;
    localparam int   ADDR_EN_PWM_LO = 2;
    localparam int   ADDR_EN_PWM_HI = 3;
    localparam int   ADDR_DUTY      = 4;
    localparam int   NUM_REGS       = 5;
    localparam int   FRAME_BITS     = 16;
    localparam logic RW_WRITE       = 1'b1;

    function automatic logic frame_rw(input logic [15:0] frame);
        return frame[15];
    endfunction

    function automatic logic [6:0] frame_addr(input logic [15:0] frame);
        return frame[14:8];
    endfunction

    function automatic logic [7:0] frame_data(input logic [15:0] frame);
        return frame[7:0];
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser for one asynchronous input, with a history flop
// that yields single-clock rise/fall pulses aligned to the synced level.
module sync_edge_det #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   hist_r;

    // Synchroniser chain plus one history stage for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{RESET_VAL}};
            hist_r <= RESET_VAL;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], din};
            hist_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign sync = sync_r[SYNC_STAGES-1];
    assign rise = sync_r[SYNC_STAGES-1] & ~hist_r;
    assign fall = ~sync_r[SYNC_STAGES-1] & hist_r;

endmodule

// File: rtl/spi_peripheral.sv
// Write-only SPI (mode 0, MSB first) register slave: 16-bit frames
// {rw, addr[6:0], data[7:0]} update one of five 8-bit control registers.
module spi_peripheral
    import spi_regs_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe
);

    logic sclk_sync_s, sclk_rise_s, sclk_fall_s;
    logic copi_sync_s, copi_rise_s, copi_fall_s;
    logic ncs_sync_s,  ncs_rise_s,  ncs_fall_s;

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .din(sclk),
        .sync(sclk_sync_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .din(copi),
        .sync(copi_sync_s), .rise(copi_rise_s), .fall(copi_fall_s)
    );

    sync_edge_det #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .din(ncs),
        .sync(ncs_sync_s), .rise(ncs_rise_s), .fall(ncs_fall_s)
    );

    logic [15:0]          shift_r,  shift_nxt_s;
    logic [4:0]           count_r,  count_nxt_s;
    logic                 ovf_r,    ovf_nxt_s;
    logic [4:0][7:0]      regs_r,   regs_nxt_s;
    logic                 strobe_r, strobe_nxt_s;
    logic [6:0]           addr_s;
    logic                 addr_ok_s;
    logic                 commit_s;

    assign addr_s    = frame_addr(shift_r);
    assign addr_ok_s = (addr_s <= 7'(MAX_ADDR)) && (addr_s < 7'(NUM_REGS));
    assign commit_s  = (count_r == 5'(FRAME_BITS)) && !ovf_r &&
                       (frame_rw(shift_r) == RW_WRITE) && addr_ok_s;

    // Frame state, register commit and strobe; ncs rise takes priority over a coincident sclk rise
    always_comb begin
        shift_nxt_s  = shift_r;
        count_nxt_s  = count_r;
        ovf_nxt_s    = ovf_r;
        regs_nxt_s   = regs_r;
        strobe_nxt_s = 1'b0;
        if (ncs_rise_s) begin
            if (commit_s) begin
                regs_nxt_s[addr_s[2:0]] = frame_data(shift_r);
                strobe_nxt_s            = 1'b1;
            end else begin
                strobe_nxt_s = 1'b0;
            end
        end else if (ncs_fall_s) begin
            count_nxt_s = 5'd0;
            ovf_nxt_s   = 1'b0;
        end else if (sclk_rise_s && !ncs_sync_s) begin
            if (count_r >= 5'(FRAME_BITS)) begin
                ovf_nxt_s = 1'b1;
            end else begin
                shift_nxt_s = {shift_r[14:0], copi_sync_s};
                count_nxt_s = count_r + 5'd1;
            end
        end else begin
            strobe_nxt_s = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r  <= 16'h0000;
            count_r  <= 5'd0;
            ovf_r    <= 1'b0;
            regs_r   <= '0;
            strobe_r <= 1'b0;
        end else begin
            shift_r  <= shift_nxt_s;
            count_r  <= count_nxt_s;
            ovf_r    <= ovf_nxt_s;
            regs_r   <= regs_nxt_s;
            strobe_r <= strobe_nxt_s;
        end
    end

    assign en_reg_out_7_0  = regs_r[ADDR_EN_OUT_LO];
    assign en_reg_out_15_8 = regs_r[ADDR_EN_OUT_HI];
    assign en_reg_pwm_7_0  = regs_r[ADDR_EN_PWM_LO];
    assign en_reg_pwm_15_8 = regs_r[ADDR_EN_PWM_HI];
    assign pwm_duty_cycle  = regs_r[ADDR_DUTY];
    assign wr_strobe       = strobe_r;

endmodule
